// File: rtl/multicycle_ctrl_if.sv
//------------------------------------------------------------------------------
// multicycle_ctrl_if : instruction fields, ALU flag and datapath controls
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Zero;
  logic [2:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       pc_en;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       illegal;

  modport master (
    input  opcode, funct, Zero,
    output ALUOp, ALUSrcA, ALUSrcB, PCSrc, pc_en, IorD, MemRead, MemWrite,
           IRWrite, RegWrite, RegDst, MemtoReg, illegal
  );

  modport slave (
    output opcode, funct, Zero,
    input  ALUOp, ALUSrcA, ALUSrcB, PCSrc, pc_en, IorD, MemRead, MemWrite,
           IRWrite, RegWrite, RegDst, MemtoReg, illegal
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
//------------------------------------------------------------------------------
// multicycle_ctrl : Moore control FSM for the single-ALU multi-cycle MIPS path
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl (
  input  logic              clk,
  input  logic              reset_n,
  multicycle_ctrl_if.master bus
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_J     = 6'h02;

  localparam logic [5:0] c_FN_ADD = 6'h20;
  localparam logic [5:0] c_FN_SUB = 6'h22;
  localparam logic [5:0] c_FN_AND = 6'h24;
  localparam logic [5:0] c_FN_OR  = 6'h25;
  localparam logic [5:0] c_FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] funct_q;
  logic       is_lw_q;
  logic       funct_ok;
  logic       pc_write;
  logic       pc_write_cond;

  // Instruction fields are captured in DECODE so later states ignore IR churn
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      funct_q <= 6'h00;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        funct_q <= bus.funct;
        is_lw_q <= (bus.opcode == c_OP_LW);
      end
    end
  end

  always_comb begin
    funct_ok = 1'b0;
    case (bus.funct)
      c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_SLT: funct_ok = 1'b1;
      default:                                         funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bus.ALUOp     = 3'b010;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 2'b00;
    bus.PCSrc     = 2'b00;
    bus.IorD      = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.RegDst    = 1'b0;
    bus.MemtoReg  = 1'b0;
    bus.illegal   = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.IRWrite = 1'b1;
        bus.ALUSrcB = 2'b01;
        pc_write    = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.opcode)
          c_OP_RTYPE: begin
            if (funct_ok) begin
              state_d = S_EXEC;
            end else begin
              bus.illegal = 1'b1;
              state_d     = S_FETCH;
            end
          end
          c_OP_LW, c_OP_SW: state_d = S_MEMADR;
          c_OP_BEQ:         state_d = S_BRANCH;
          c_OP_ADDI:        state_d = S_ADDIEX;
          c_OP_J:           state_d = S_JUMP;
          default: begin
            bus.illegal = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = is_lw_q ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        state_d     = S_MEMWB;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        state_d      = S_FETCH;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        case (funct_q)
          c_FN_ADD: bus.ALUOp = 3'b010;
          c_FN_SUB: bus.ALUOp = 3'b110;
          c_FN_AND: bus.ALUOp = 3'b000;
          c_FN_OR:  bus.ALUOp = 3'b001;
          c_FN_SLT: bus.ALUOp = 3'b111;
          default:  bus.ALUOp = 3'b010;
        endcase
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUOp     = 3'b110;
        bus.PCSrc     = 2'b01;
        pc_write_cond = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.RegWrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        bus.PCSrc = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Zero is consumed in the cycle it arrives, so the branch decision stays combinational
  assign bus.pc_en = pc_write | (pc_write_cond & bus.Zero);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// tb_multicycle_ctrl : instruction-level reference model with per-cycle compare
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcw;
    logic       pcc;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       ill;
  } vec_t;

  localparam logic [16:0] c_FETCH_VEC = 17'b010_0_01_00_1_0_1_0_1_0_0_0_0;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  vec_t        steps[$];
  logic [16:0] exp_q[$];

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] dut_vec();
    return {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.pc_en, bus.IorD,
            bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.RegDst,
            bus.MemtoReg, bus.illegal};
  endfunction

  function automatic logic [16:0] pack(input vec_t v, input logic z);
    return {v.aluop, v.srca, v.srcb, v.pcsrc, v.pcw | (v.pcc & z), v.iord,
            v.mr, v.mw, v.irw, v.rw, v.rd, v.m2r, v.ill};
  endfunction

  function automatic vec_t base();
    vec_t v;
    v = '0;
    v.aluop = 3'b010;
    return v;
  endfunction

  // Per-instruction cycle list built straight from the instruction's meaning
  task automatic model_seq(input logic [5:0] op, input logic [5:0] fn);
    vec_t f, d, x, w;
    logic [2:0] rop;
    logic       rlegal;
    steps.delete();
    f = base(); f.mr = 1; f.irw = 1; f.srcb = 2'b01; f.pcw = 1;
    steps.push_back(f);
    d = base(); d.srcb = 2'b11;
    rlegal = 1'b1;
    case (fn)
      6'h20: rop = 3'b010;
      6'h22: rop = 3'b110;
      6'h24: rop = 3'b000;
      6'h25: rop = 3'b001;
      6'h2A: rop = 3'b111;
      default: begin rop = 3'b010; rlegal = 1'b0; end
    endcase
    x = base(); x.srca = 1;
    w = base();
    case (op)
      6'h00: begin
        if (rlegal) begin
          x.aluop = rop; w.rw = 1; w.rd = 1;
          steps.push_back(d); steps.push_back(x); steps.push_back(w);
        end else begin
          d.ill = 1; steps.push_back(d);
        end
      end
      6'h23, 6'h2B: begin
        x.srcb = 2'b10;
        steps.push_back(d); steps.push_back(x);
        if (op == 6'h23) begin
          w.mr = 1; w.iord = 1; steps.push_back(w);
          w = base(); w.rw = 1; w.m2r = 1; steps.push_back(w);
        end else begin
          w.mw = 1; w.iord = 1; steps.push_back(w);
        end
      end
      6'h04: begin
        x.aluop = 3'b110; x.pcsrc = 2'b01; x.pcc = 1;
        steps.push_back(d); steps.push_back(x);
      end
      6'h08: begin
        x.srcb = 2'b10; w.rw = 1;
        steps.push_back(d); steps.push_back(x); steps.push_back(w);
      end
      6'h02: begin
        w.pcsrc = 2'b10; w.pcw = 1;
        steps.push_back(d); steps.push_back(w);
      end
      default: begin
        d.ill = 1; steps.push_back(d);
      end
    endcase
  endtask

  // zsel < 0 randomises Zero each cycle; nsteps < 0 runs the whole instruction
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zsel, input int nsteps);
    int   n;
    logic z;
    model_seq(op, fn);
    n = (nsteps < 0) ? steps.size() : nsteps;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        bus.opcode = 6'($urandom);
        bus.funct  = 6'($urandom);
      end else begin
        bus.opcode = op;
        bus.funct  = (i > 1 && op == 6'h00) ? 6'($urandom) : fn;
      end
      z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
      bus.Zero = z;
      exp_q.push_back(pack(steps[i], z));
      @(posedge clk); #1;
    end
  endtask

  task automatic measure_len(input logic [5:0] op, input logic [5:0] fn, input int exp_len);
    int n;
    n = 0;
    bus.opcode = op;
    bus.funct  = fn;
    bus.Zero   = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.IRWrite !== 1'b1 && n < 12);
    vectors++;
    if (n != exp_len) begin
      miscompares++;
      $display("FAIL len_op%02h_fn%02h: got %0d cycles want %0d", op, fn, n, exp_len);
    end
  endtask

  task automatic check_lit(input string name, input logic [16:0] act, input logic [16:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  initial begin
    logic [16:0] e;
    logic [16:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_vec();
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle@%0t: got %b want %b", $time, a, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] op, fn;
    logic [5:0] legal_fn [5];
    int         sel;
    legal_fn[0] = 6'h20; legal_fn[1] = 6'h22; legal_fn[2] = 6'h24;
    legal_fn[3] = 6'h25; legal_fn[4] = 6'h2A;

    reset_n    = 1'b0;
    bus.opcode = 6'h00;
    bus.funct  = 6'h00;
    bus.Zero   = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check_lit("reset_vec", dut_vec(), c_FETCH_VEC);
      @(posedge clk); #1;
    end
    reset_n = 1'b1;

    run_instr(6'h00, 6'h22, -1, -1);
    run_instr(6'h23, 6'h00, -1, -1);
    run_instr(6'h2B, 6'h11, -1, -1);
    run_instr(6'h04, 6'h00,  1, -1);
    run_instr(6'h04, 6'h00,  0, -1);
    run_instr(6'h08, 6'h00, -1, -1);
    run_instr(6'h02, 6'h00, -1, -1);
    run_instr(6'h3F, 6'h20, -1, -1);
    run_instr(6'h00, 6'h27, -1, -1);
    for (int i = 0; i < 5; i++) run_instr(6'h00, legal_fn[i], -1, -1);

    measure_len(6'h23, 6'h00, 5);
    measure_len(6'h2B, 6'h00, 4);
    measure_len(6'h00, 6'h2A, 4);
    measure_len(6'h08, 6'h00, 4);
    measure_len(6'h04, 6'h00, 3);
    measure_len(6'h02, 6'h00, 3);
    measure_len(6'h3F, 6'h00, 2);

    // Reset pulse while a store is in its write cycle
    run_instr(6'h2B, 6'h00, 0, 3);
    check_lit("memwr_before_rst", 17'(bus.MemWrite), 17'd1);
    #1 reset_n = 1'b0;
    #1;
    check_lit("memwr_during_rst", 17'(bus.MemWrite), 17'd0);
    check_lit("vec_during_rst", dut_vec(), c_FETCH_VEC);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_instr(6'h00, 6'h24, -1, -1);

    for (int k = 0; k < 120; k++) begin
      sel = $urandom_range(0, 9);
      fn  = 6'($urandom);
      case (sel)
        0, 1: begin op = 6'h00; fn = legal_fn[$urandom_range(0, 4)]; end
        2:       op = 6'h23;
        3:       op = 6'h2B;
        4:       op = 6'h04;
        5:       op = 6'h08;
        6:       op = 6'h02;
        7:       op = 6'h00;
        default: op = 6'($urandom);
      endcase
      run_instr(op, fn, -1, -1);
    end

    @(posedge clk); #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the single-ALU MIPS datapath. A registered state machine sequences instruction fetch, decode, execute, memory and write-back. In every cycle it drives the 3-bit ALU operation code and all datapath enables and mux selects. It sits directly upstream of the ALU and also consumes the ALU's Zero flag to resolve branches.

## Interface
Parameters: none. Opcodes and funct codes are fixed by the MIPS encoding.

Ports:
- clk  input  1  single system clock; all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- opcode  input  6  instruction register bits [31:26]
- funct  input  6  instruction register bits [5:0]
- Zero  input  1  ALU zero flag, same cycle
- ALUOp  output  3  ALU code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2
- PCSrc  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump target
- pc_en  output  1  PCWrite | (PCWriteCond & Zero)
- IorD, MemRead, MemWrite, IRWrite  output  1 each  memory address select and memory/IR strobes
- RegWrite, RegDst, MemtoReg  output  1 each  register file write controls
- illegal  output  1  one-cycle pulse on unsupported opcode or funct

## Operation
- Moore machine: every output except pc_en and illegal decodes from the registered state only.
- Outputs default to 0 and ALUOp defaults to 010, except where a state below sets them.
- States and actions:
  - FETCH: MemRead, IRWrite, ALUSrcB=01, ALUOp=010, PCWrite, PCSrc=00. Go to DECODE.
  - DECODE: ALUSrcB=11, ALUOp=010 (computes the branch target). Next state by opcode:
    - 0x00 R-type → EXEC, but only if funct ∈ {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt}.
    - 0x23 lw or 0x2B sw → MEMADR.
    - 0x04 beq → BRANCH.
    - 0x08 addi → ADDIEX.
    - 0x02 j → JUMP.
    - Anything else, or an unsupported R-type funct → FETCH, with illegal=1 for that cycle.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=010. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD: MemRead, IorD. Go to MEMWB.
  - MEMWB: RegWrite, MemtoReg. Go to FETCH.
  - MEMWR: MemWrite, IorD. Go to FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp mapped from funct: add→010, sub→110, and→000, or→001, slt→111. Go to ALUWB.
  - ALUWB: RegWrite, RegDst. Go to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=110, PCSrc=01, PCWriteCond. Go to FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=010. Go to ADDIWB.
  - ADDIWB: RegWrite, with RegDst=0 and MemtoReg=0. Go to FETCH.
  - JUMP: PCSrc=10, PCWrite. Go to FETCH.
- pc_en is combinational: PCWrite | (PCWriteCond & Zero). It is therefore asserted in FETCH and JUMP, and in BRANCH only when Zero=1.
- EXEC holds funct as it was sampled in DECODE: a 6-bit funct register loads on DECODE. This keeps EXEC immune to IR changes.

## Timing
- Reset asserted, at any time and in any state: state goes to FETCH immediately and asynchronously; the funct register clears to 0.
- Outputs during reset are the FETCH outputs: MemRead=1, IRWrite=1, ALUSrcB=01, ALUOp=010, pc_en=1, everything else 0.
- Downstream write enables stay gated by reset_n in the datapath.
- First FETCH action occurs on the first rising edge after reset_n deasserts.
- opcode and funct are sampled in DECODE, one cycle after the IRWrite edge.
- Cycle counts, FETCH through the last state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Zero is used in the same cycle it arrives (BRANCH). No registered copy is used.
- Reset released mid-instruction: the aborted instruction produces no RegWrite or MemWrite once reset_n is low, because the state is FETCH.

## Test plan
- Reset held low 3 cycles, then released → outputs equal the FETCH vector during reset. First edge after release moves to DECODE.
- opcode=0x00, funct=0x22 → states FETCH, DECODE, EXEC (ALUOp=110), ALUWB (RegWrite=1, RegDst=1) → FETCH; 4 cycles.
- opcode=0x23 → MEMADR (ALUSrcB=10), MEMRD (IorD=1, MemRead=1), MEMWB (MemtoReg=1) → FETCH; 5 cycles, MemWrite never 1.
- opcode=0x04 with Zero=1 in BRANCH → pc_en=1, PCSrc=01. Repeat with Zero=0 → pc_en=0. Both return to FETCH after 3 cycles.
- opcode=0x3F, then opcode=0x00 with funct=0x27 → illegal=1 for exactly one DECODE cycle, next state FETCH, no RegWrite or MemWrite.
- reset_n pulsed low during MEMWR → MemWrite drops in the same cycle without waiting for a clock edge; state is FETCH after release.
